sub_result_stage: RTL
=====================

# sub_result_stage

Registered output stage directly downstream of the N-bit subtractor. Captures each difference and carry-out, derives N/Z/C/V status flags, and presents result plus flags to the display/control logic over a valid/ready handshake. A 2-entry skid buffer keeps full throughput of one result per cycle under back-pressure.

## Interface
- `N`, default 4: operand and result width, N >= 2.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  upstream subtractor result is valid this cycle.
- `in_ready`  out  1  stage can accept a beat.
- `diferencia`  in  N  difference from subtractor.
- `cout`  in  1  subtractor carry-out; 1 = no borrow.
- `minuendo_msb`  in  1  sign bit of minuend.
- `sustraendo_msb`  in  1  sign bit of subtrahend.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts beat.
- `resultado`  out  N  registered difference.
- `flag_n`, `flag_z`, `flag_c`, `flag_v`  out  1 each  negative, zero, carry, signed overflow.
- `clr_sticky`  in  1  clears sticky overflow; present only with STICKY_V_EN.
- `flag_v_sticky`  out  1  sticky overflow; present only with STICKY_V_EN.

## Operation
- Input transfer: `in_valid && in_ready` on a rising edge. Output transfer: `out_valid && out_ready`.
- Flags computed at capture from input beat:
  - N = diferencia[N-1].
  - Z = (diferencia == 0).
  - C = cout.
  - V = (minuendo_msb != sustraendo_msb) && (diferencia[N-1] != minuendo_msb).
- Storage: main register (drives outputs) and skid register, each holding {resultado, N, Z, C, V}.
- FSM states:
  - EMPTY: out_valid=0, in_ready=1. Input transfer goes to main, then ONE.
  - ONE: out_valid=1, in_ready=1.
    - Input only: load skid, go to FULL.
    - Output only: go to EMPTY.
    - Input and output together: load main, stay in ONE.
  - FULL: out_valid=1, in_ready=0.
    - Output transfer: copy skid into main, go to ONE.
- `in_ready` is a registered function of state; it has no combinational path from `out_ready`.
- Beats leave in arrival order. None are dropped or duplicated.
- While out_valid=1 and out_ready=0, all outputs hold stable.
- `in_valid` while `in_ready=0` is ignored. Upstream must hold the beat.

## Timing
- Latency: a beat accepted at edge k appears on outputs after edge k (valid in cycle k+1) when state was EMPTY.
- Throughput: 1 beat/cycle with out_ready held high.
- Reset (synchronous, any state including FULL mid-stall) forces on the next edge:
  - state EMPTY, out_valid=0, in_ready=1.
  - resultado=0, all flags 0, flag_v_sticky=0.
  - Buffered beats are discarded.
- During the reset cycle, input beats are not captured.

## Configuration
- `STICKY_V_EN` defined:
  - Adds `clr_sticky` and `flag_v_sticky`.
  - flag_v_sticky sets the cycle after any output transfer with V=1.
  - Stays set until clr_sticky=1 or reset.
  - If clr_sticky and a V=1 transfer occur in the same cycle, set wins.
- Not defined: both ports and the sticky logic are absent. Remaining behaviour is identical.

## Structure
- Package `alu_pkg`:
  - `alu_flags_t` packed struct {n, z, c, v}.
  - FSM state enum {EMPTY, ONE, FULL}.
- Sub-module `sub_flag_calc`: combinational N/Z/C/V derivation from diferencia, cout and the two MSBs. It is reusable for the adder stage.
- Top module holds the FSM, the main/skid registers and the sticky logic.

## Test plan
- N=4, 5−3: diferencia=0010, cout=1, msbs 0/0 -> resultado=0010, N0 Z0 C1 V0, one cycle after capture.
- 3−5: diferencia=1110, cout=0, msbs 0/0 -> N1 Z0 C0 V0.
- 7−(−1): diferencia=1000, cout=0, msbs 0/1 -> N1 Z0 C0 V1; with STICKY_V_EN, flag_v_sticky=1 until clr_sticky pulse.
- 4−4: diferencia=0000, cout=1 -> Z1 C1 N0 V0.
- Back-pressure: out_ready=0, offer beats A, B, C on consecutive cycles -> A and B accepted, in_ready=0 after B, C held. Raise out_ready -> A, B, C delivered in order, one per cycle.
- Reset in FULL: assert rst one cycle -> out_valid=0, in_ready=1, resultado=0, flags 0. Next beat enters cleanly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU result stages.
// Flag bundle and output-stage FSM encoding.
package alu_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/sub_result_stage_if.sv
// Valid/ready bundle between subtractor, result stage and consumer.
// master drives beats in and accepts results; slave is the stage.
interface sub_result_stage_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] diferencia;
    logic         cout;
    logic         minuendo_msb;
    logic         sustraendo_msb;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] resultado;
    logic         flag_n;
    logic         flag_z;
    logic         flag_c;
    logic         flag_v;

    modport master (
        output in_valid,
        output diferencia,
        output cout,
        output minuendo_msb,
        output sustraendo_msb,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  resultado,
        input  flag_n,
        input  flag_z,
        input  flag_c,
        input  flag_v
    );

    modport slave (
        input  in_valid,
        input  diferencia,
        input  cout,
        input  minuendo_msb,
        input  sustraendo_msb,
        input  out_ready,
        output in_ready,
        output out_valid,
        output resultado,
        output flag_n,
        output flag_z,
        output flag_c,
        output flag_v
    );
endinterface

// File: rtl/sub_flag_calc.sv
// Combinational N/Z/C/V derivation for a subtract (or add) result.
// Operand MSBs are passed in so the same block serves the adder stage.
module sub_flag_calc
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] diferencia,
    input  logic         cout,
    input  logic         minuendo_msb,
    input  logic         sustraendo_msb,
    output alu_flags_t   flags
);

    // Overflow: operands of opposite sign and result sign differs from minuend.
    always_comb begin
        flags   = '0;
        flags.n = diferencia[N-1];
        flags.z = (diferencia == '0);
        flags.c = cout;
        flags.v = (minuendo_msb != sustraendo_msb) &&
                  (diferencia[N-1] != minuendo_msb);
    end

endmodule

// File: rtl/sub_result_stage.sv
// Registered subtractor output stage with 2-entry skid buffer.
// Optional sticky overflow flag enabled by defining STICKY_V_EN.
module sub_result_stage
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef STICKY_V_EN
    input  logic clr_sticky,
    output logic flag_v_sticky,
`endif
    sub_result_stage_if.slave bus
);

    alu_flags_t   in_flags;
    stage_state_t state_q, state_d;
    logic [N-1:0] main_res_q, main_res_d;
    logic [N-1:0] skid_res_q, skid_res_d;
    alu_flags_t   main_flags_q, main_flags_d;
    alu_flags_t   skid_flags_q, skid_flags_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         in_fire;
    logic         out_fire;

    sub_flag_calc #(
        .N(N)
    ) u_flag_calc (
        .diferencia     (bus.diferencia),
        .cout           (bus.cout),
        .minuendo_msb   (bus.minuendo_msb),
        .sustraendo_msb (bus.sustraendo_msb),
        .flags          (in_flags)
    );

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    // Next state, main/skid loads and registered handshake outputs.
    always_comb begin
        state_d      = state_q;
        main_res_d   = main_res_q;
        main_flags_d = main_flags_q;
        skid_res_d   = skid_res_q;
        skid_flags_d = skid_flags_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_res_d   = bus.diferencia;
                    main_flags_d = in_flags;
                    state_d      = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_res_d   = bus.diferencia;
                    main_flags_d = in_flags;
                end else if (in_fire) begin
                    skid_res_d   = bus.diferencia;
                    skid_flags_d = in_flags;
                    state_d      = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_res_d   = skid_res_q;
                    main_flags_d = skid_flags_q;
                    state_d      = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // State and storage registers; reset discards buffered beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            main_res_q   <= '0;
            main_flags_q <= '0;
            skid_res_q   <= '0;
            skid_flags_q <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            main_res_q   <= main_res_d;
            main_flags_q <= main_flags_d;
            skid_res_q   <= skid_res_d;
            skid_flags_q <= skid_flags_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.resultado = main_res_q;
    assign bus.flag_n    = main_flags_q.n;
    assign bus.flag_z    = main_flags_q.z;
    assign bus.flag_c    = main_flags_q.c;
    assign bus.flag_v    = main_flags_q.v;

`ifdef STICKY_V_EN
    logic sticky_q, sticky_d;

    // Sticky overflow: a delivered V=1 beat wins over a clear request.
    always_comb begin
        sticky_d = sticky_q;
        if (clr_sticky) begin
            sticky_d = 1'b0;
        end
        if (out_fire && main_flags_q.v) begin
            sticky_d = 1'b1;
        end
    end

    // Sticky overflow register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign flag_v_sticky = sticky_q;
`endif

endmodule
